// File: rtl/uart_pkg.sv
// Shared types, IIR codes and helper functions for the UART receive-side
// interrupt controller.
package uart_pkg;

    // Receive interrupt sources, encoded in the order the FSM registers them.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        LS   = 2'd1,
        RDA  = 2'd2,
        CTI  = 2'd3
    } int_state_t;

    // 16550-style interrupt identification codes.
    localparam logic [3:0] IIR_NONE = 4'b0001;
    localparam logic [3:0] IIR_LS   = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_CTI  = 4'b1100;

    // RX FIFO trigger level selected by FCR[7:6].
    function automatic logic [4:0] trig_level(input logic [1:0] fcr_trig);
        logic [4:0] lvl;
        case (fcr_trig)
            2'b00:   lvl = 5'd1;
            2'b01:   lvl = 5'd4;
            2'b10:   lvl = 5'd8;
            default: lvl = 5'd14;
        endcase
        return lvl;
    endfunction

    // Bits per character on the wire: start + data + parity + stop(s), 7..12.
    // Only LCR[3:0] influences the frame length.
    function automatic logic [3:0] char_bits(input logic [3:0] lcr_lo);
        return 4'd7 + {2'b00, lcr_lo[1:0]} + {3'b000, lcr_lo[3]} + {3'b000, lcr_lo[2]};
    endfunction

    // IIR value reported for each interrupt state.
    function automatic logic [3:0] iir_code(input int_state_t st);
        logic [3:0] code;
        case (st)
            LS:      code = IIR_LS;
            RDA:     code = IIR_RDA;
            CTI:     code = IIR_CTI;
            default: code = IIR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Character-timeout detector: counts 16x baud ticks while the RX FIFO holds
// data but sees no push or pop, and raises cti_pend once the count reaches
// CTI_CHARS character times for the current line format.
module uart_rx_timeout
    import uart_pkg::*;
#(
    parameter int CTI_CHARS = 4,
    parameter int CNT_W     = 10
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       enable,
    input  logic [3:0] lcr_lo,
    input  logic       push_rx_fifo,
    input  logic       pop_rx_fifo,
    input  logic       rbr_rd,
    input  logic       fifo_empty,
    output logic       cti_pend
);

    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cti_q, cti_d;

    // Threshold follows LCR live, so a format change applies on the next compare.
    assign thr = CNT_W'(CTI_CHARS * 16 * int'(char_bits(lcr_lo)));

    // Next counter value: any FIFO activity or an empty FIFO restarts it,
    // otherwise count ticks and saturate at the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (push_rx_fifo || pop_rx_fifo || fifo_empty) begin
            cnt_d = '0;
        end else if (enable && (cnt_q < thr)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pending flag: clearing events win over a coincident threshold hit.
    always_comb begin
        cti_d = cti_q;
        if (rbr_rd || push_rx_fifo || fifo_empty) begin
            cti_d = 1'b0;
        end else if (cnt_d >= thr) begin
            cti_d = 1'b1;
        end
    end

    // Counter and pending-flag registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
            cti_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cti_q <= cti_d;
        end
    end

    assign cti_pend = cti_q;

endmodule

// File: rtl/uart_rx_int_ctrl.sv
// Receive-side interrupt and status controller for the APB UART.
// Sequences RX FIFO pops from RBR reads, keeps the sticky LSR error bits and
// runs the receive interrupt FSM (LS > RDA > CTI > NONE).
// Build option: define UART_RX_TIMEOUT_EN to include the character-timeout
// counter and the CTI interrupt source; without it cti_pend is tied low.
//
// Handshake note: rbr_rd, lsr_rd and iir_rd are single-cycle strobes; a pop
// is issued the cycle after an accepted rbr_rd and rbr_rd is ignored while
// that pop pulse is high, so pops are at least two cycles apart.
module uart_rx_int_ctrl
    import uart_pkg::*;
#(
    parameter int CTI_CHARS = 4,
    parameter int CNT_W     = 10
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       enable,
    input  logic [7:0] LCR,
    input  logic [1:0] FCR_trig,
    input  logic       IER_rda,
    input  logic       IER_ls,
    input  logic [4:0] rx_fifo_count,
    input  logic [2:0] rx_fifo_err,
    input  logic       push_rx_fifo,
    input  logic       rx_overrun,
    input  logic       rbr_rd,
    input  logic       lsr_rd,
    input  logic       iir_rd,
    output logic       pop_rx_fifo,
    output logic [3:0] lsr_err,
    output logic       data_ready,
    output logic [3:0] iir,
    output logic       rx_irq
);

    logic       fifo_nempty;
    logic       pop_q, pop_d;
    logic [3:0] err_set;
    logic [3:0] lsr_err_q, lsr_err_d;
    int_state_t state_q, state_d;
    logic [3:0] iir_q;
    logic       irq_q;
    logic       cti_pend;

    assign fifo_nempty = (rx_fifo_count != 5'd0);
    assign data_ready  = fifo_nempty;

`ifdef UART_RX_TIMEOUT_EN
    logic [3:0] unused_lcr_hi;
    assign unused_lcr_hi = LCR[7:4];

    uart_rx_timeout #(
        .CTI_CHARS (CTI_CHARS),
        .CNT_W     (CNT_W)
    ) u_timeout (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .enable       (enable),
        .lcr_lo       (LCR[3:0]),
        .push_rx_fifo (push_rx_fifo),
        .pop_rx_fifo  (pop_q),
        .rbr_rd       (rbr_rd),
        .fifo_empty   (!fifo_nempty),
        .cti_pend     (cti_pend)
    );
`else
    logic [8:0]  unused_tick_lcr;
    logic [31:0] unused_params;
    assign unused_tick_lcr = {enable, LCR};
    assign unused_params   = CTI_CHARS + CNT_W;
    assign cti_pend        = 1'b0;
`endif

    // Pop request: accept rbr_rd only with data present and no pop in flight.
    always_comb begin
        pop_d = rbr_rd && fifo_nempty && !pop_q;
    end

    // Sticky error next-state: {BI, FE, PE, OE}; a new set beats an LSR read clear.
    always_comb begin
        err_set   = {fifo_nempty & rx_fifo_err[2],
                     fifo_nempty & rx_fifo_err[0],
                     fifo_nempty & rx_fifo_err[1],
                     push_rx_fifo & rx_overrun};
        lsr_err_d = lsr_rd ? err_set : (lsr_err_q | err_set);
    end

    // Pop pulse and sticky error registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pop_q     <= 1'b0;
            lsr_err_q <= 4'b0000;
        end else begin
            pop_q     <= pop_d;
            lsr_err_q <= lsr_err_d;
        end
    end

    // Highest-priority active receive interrupt source.
    always_comb begin
        state_d = NONE;
        if (IER_ls && (|lsr_err_q)) begin
            state_d = LS;
        end else if (IER_rda && (rx_fifo_count >= trig_level(FCR_trig))) begin
            state_d = RDA;
        end else if (IER_rda && cti_pend) begin
            state_d = CTI;
        end
    end

    // Interrupt FSM with registered IIR/IRQ; frozen while IIR is being read.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= NONE;
            iir_q   <= IIR_NONE;
            irq_q   <= 1'b0;
        end else if (!iir_rd) begin
            state_q <= state_d;
            iir_q   <= iir_code(state_d);
            irq_q   <= (state_d != NONE);
        end
    end

    assign pop_rx_fifo = pop_q;
    assign lsr_err     = lsr_err_q;
    assign iir         = iir_q;
    assign rx_irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_int_ctrl.sv
// Self-checking bench for uart_rx_int_ctrl: table-driven RDA/trigger vectors
// plus directed sequences for pops, sticky errors, IIR read hold, reset and
// (when UART_RX_TIMEOUT_EN is defined) the character timeout.
module tb_uart_rx_int_ctrl;

    logic       PCLK;
    logic       PRESETn;
    logic       enable;
    logic [7:0] LCR;
    logic [1:0] FCR_trig;
    logic       IER_rda;
    logic       IER_ls;
    logic [4:0] rx_fifo_count;
    logic [2:0] rx_fifo_err;
    logic       push_rx_fifo;
    logic       rx_overrun;
    logic       rbr_rd;
    logic       lsr_rd;
    logic       iir_rd;
    logic       pop_rx_fifo;
    logic [3:0] lsr_err;
    logic       data_ready;
    logic [3:0] iir;
    logic       rx_irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] trig;
        logic [4:0] count;
        logic       rda;
        logic [3:0] exp_iir;
        logic       exp_irq;
        logic       exp_dr;
    } vec_t;

    vec_t vecs[11];

    uart_rx_int_ctrl dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .enable        (enable),
        .LCR           (LCR),
        .FCR_trig      (FCR_trig),
        .IER_rda       (IER_rda),
        .IER_ls        (IER_ls),
        .rx_fifo_count (rx_fifo_count),
        .rx_fifo_err   (rx_fifo_err),
        .push_rx_fifo  (push_rx_fifo),
        .rx_overrun    (rx_overrun),
        .rbr_rd        (rbr_rd),
        .lsr_rd        (lsr_rd),
        .iir_rd        (iir_rd),
        .pop_rx_fifo   (pop_rx_fifo),
        .lsr_err       (lsr_err),
        .data_ready    (data_ready),
        .iir           (iir),
        .rx_irq        (rx_irq)
    );

    // Clock generation.
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        enable       = 1'b0;
        LCR          = 8'h03;
        FCR_trig     = 2'b00;
        IER_rda      = 1'b0;
        IER_ls       = 1'b0;
        rx_fifo_count = 5'd0;
        rx_fifo_err  = 3'b000;
        push_rx_fifo = 1'b0;
        rx_overrun   = 1'b0;
        rbr_rd       = 1'b0;
        lsr_rd       = 1'b0;
        iir_rd       = 1'b0;
    endtask

    task automatic clear_lsr();
        lsr_rd = 1'b1;
        tick();
        lsr_rd = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0]  = '{2'b00, 5'd0,  1'b1, 4'b0001, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 5'd1,  1'b1, 4'b0100, 1'b1, 1'b1};
        vecs[2]  = '{2'b01, 5'd3,  1'b1, 4'b0001, 1'b0, 1'b1};
        vecs[3]  = '{2'b01, 5'd4,  1'b1, 4'b0100, 1'b1, 1'b1};
        vecs[4]  = '{2'b10, 5'd7,  1'b1, 4'b0001, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 5'd8,  1'b1, 4'b0100, 1'b1, 1'b1};
        vecs[6]  = '{2'b11, 5'd13, 1'b1, 4'b0001, 1'b0, 1'b1};
        vecs[7]  = '{2'b11, 5'd14, 1'b1, 4'b0100, 1'b1, 1'b1};
        vecs[8]  = '{2'b11, 5'd16, 1'b1, 4'b0100, 1'b1, 1'b1};
        vecs[9]  = '{2'b11, 5'd16, 1'b0, 4'b0001, 1'b0, 1'b1};
        vecs[10] = '{2'b00, 5'd0,  1'b1, 4'b0001, 1'b0, 1'b0};

        idle_inputs();
        PRESETn = 1'b0;
        #12;
        // Reset values
        check("rst_pop", {7'd0, pop_rx_fifo}, 8'd0);
        check("rst_lsr", {4'd0, lsr_err}, 8'd0);
        check("rst_iir", {4'd0, iir}, 8'h01);
        check("rst_irq", {7'd0, rx_irq}, 8'd0);
        PRESETn = 1'b1;
        tick();

        // Trigger-level table
        for (int i = 0; i < 11; i++) begin
            FCR_trig      = vecs[i].trig;
            rx_fifo_count = vecs[i].count;
            IER_rda       = vecs[i].rda;
            tick();
            check($sformatf("vec%0d_iir", i), {4'd0, iir}, {4'd0, vecs[i].exp_iir});
            check($sformatf("vec%0d_irq", i), {7'd0, rx_irq}, {7'd0, vecs[i].exp_irq});
            check($sformatf("vec%0d_dr", i), {7'd0, data_ready}, {7'd0, vecs[i].exp_dr});
        end

        // IIR held during an IIR read, updated the cycle after
        FCR_trig = 2'b00; IER_rda = 1'b1; rx_fifo_count = 5'd0;
        tick();
        rx_fifo_count = 5'd1; iir_rd = 1'b1;
        tick();
        check("iirrd_hold", {4'd0, iir}, 8'h01);
        iir_rd = 1'b0;
        tick();
        check("iirrd_after", {4'd0, iir}, 8'h04);

        // Trigger 8: seven pushes then the eighth
        rx_fifo_count = 5'd0; FCR_trig = 2'b10;
        tick();
        for (int k = 1; k <= 8; k++) begin
            push_rx_fifo  = 1'b1;
            rx_fifo_count = 5'(k);
            tick();
            check($sformatf("trig8_push%0d_iir", k), {4'd0, iir}, (k >= 8) ? 8'h04 : 8'h01);
        end
        push_rx_fifo = 1'b0;
        check("trig8_irq", {7'd0, rx_irq}, 8'd1);

        // Parity error on head entry overrides RDA
        IER_ls = 1'b1; rx_fifo_err = 3'b010;
        tick();
        check("pe_lsr", {4'd0, lsr_err}, 8'h02);
        rx_fifo_err = 3'b000;
        tick();
        check("pe_iir_ls", {4'd0, iir}, 8'h06);
        check("pe_irq", {7'd0, rx_irq}, 8'd1);
        lsr_rd = 1'b1;
        tick();
        check("pe_lsr_clr", {4'd0, lsr_err}, 8'h00);
        lsr_rd = 1'b0;
        tick();
        check("pe_iir_back", {4'd0, iir}, 8'h04);

        // Break and framing map to BI and FE
        rx_fifo_err = 3'b101;
        tick();
        rx_fifo_err = 3'b000;
        check("bi_fe_lsr", {4'd0, lsr_err}, 8'h0C);
        clear_lsr();
        // Errors ignored with an empty FIFO
        rx_fifo_count = 5'd0; rx_fifo_err = 3'b111;
        tick();
        rx_fifo_err = 3'b000;
        check("err_empty", {4'd0, lsr_err}, 8'h00);

        // Overrun on a full FIFO, set beats same-cycle LSR read
        rx_fifo_count = 5'd16; push_rx_fifo = 1'b1; rx_overrun = 1'b1; lsr_rd = 1'b1;
        tick();
        check("oe_set_wins", {4'd0, lsr_err}, 8'h01);
        push_rx_fifo = 1'b0; rx_overrun = 1'b0;
        tick();
        check("oe_clear", {4'd0, lsr_err}, 8'h00);
        lsr_rd = 1'b0;
        tick();

        // Pop sequencing
        rx_fifo_count = 5'd0; rbr_rd = 1'b1;
        tick();
        check("pop_empty", {7'd0, pop_rx_fifo}, 8'd0);
        rbr_rd = 1'b0;
        rx_fifo_count = 5'd2;
        tick();
        rbr_rd = 1'b1;
        tick();
        check("pop_first", {7'd0, pop_rx_fifo}, 8'd1);
        tick();
        check("pop_b2b_ignored", {7'd0, pop_rx_fifo}, 8'd0);
        rbr_rd = 1'b0;
        tick();
        check("pop_idle", {7'd0, pop_rx_fifo}, 8'd0);

        // Asynchronous reset mid-operation
        IER_ls = 1'b1; rx_fifo_count = 5'd16; push_rx_fifo = 1'b1; rx_overrun = 1'b1;
        tick();
        push_rx_fifo = 1'b0; rx_overrun = 1'b0; rbr_rd = 1'b1;
        tick();
        rbr_rd = 1'b0;
        check("pre_rst_pop", {7'd0, pop_rx_fifo}, 8'd1);
        check("pre_rst_iir", {4'd0, iir}, 8'h06);
        #2;
        PRESETn = 1'b0;
        #1;
        check("async_rst_pop", {7'd0, pop_rx_fifo}, 8'd0);
        check("async_rst_lsr", {4'd0, lsr_err}, 8'd0);
        check("async_rst_iir", {4'd0, iir}, 8'h01);
        check("async_rst_irq", {7'd0, rx_irq}, 8'd0);
        idle_inputs();
        PRESETn = 1'b1;
        tick();

        // Character timeout, 8N1 -> 640 ticks
        LCR = 8'h03; FCR_trig = 2'b11; IER_rda = 1'b1;
        push_rx_fifo = 1'b1; rx_fifo_count = 5'd1;
        tick();
        push_rx_fifo = 1'b0; enable = 1'b1;
        for (int t = 0; t < 640; t++) tick();
        check("cti_not_yet", {4'd0, iir}, 8'h01);
        tick();
`ifdef UART_RX_TIMEOUT_EN
        check("cti_iir", {4'd0, iir}, 8'h0C);
        check("cti_irq", {7'd0, rx_irq}, 8'd1);
        rbr_rd = 1'b1;
        tick();
        rbr_rd = 1'b0;
        check("cti_pop", {7'd0, pop_rx_fifo}, 8'd1);
        rx_fifo_count = 5'd0;
        tick();
        check("cti_cleared", {4'd0, iir}, 8'h01);

        // Reset during a pending CTI
        push_rx_fifo = 1'b1; rx_fifo_count = 5'd1;
        tick();
        push_rx_fifo = 1'b0;
        for (int t = 0; t < 641; t++) tick();
        check("cti2_iir", {4'd0, iir}, 8'h0C);
        #1;
        PRESETn = 1'b0;
        #1;
        check("cti_rst_iir", {4'd0, iir}, 8'h01);
        check("cti_rst_irq", {7'd0, rx_irq}, 8'd0);
        #1;
        PRESETn = 1'b1;
        for (int t = 0; t < 600; t++) tick();
        check("cti_no_return", {4'd0, iir}, 8'h01);
        begin
            int waited;
            waited = 0;
            while (iir !== 4'b1100 && waited < 80) begin
                tick();
                waited++;
            end
            check("cti_returns", {4'd0, iir}, 8'h0C);
        end
`else
        check("no_cti_iir", {4'd0, iir}, 8'h01);
        for (int t = 0; t < 100; t++) tick();
        check("no_cti_later", {4'd0, iir}, 8'h01);
        check("no_cti_irq", {7'd0, rx_irq}, 8'd0);
`endif
        enable = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
